// File: rtl/led_cube_scanner.sv
// Frame scanner for an 8x8x8 LED cube: walks the voxel frame buffer, skips dark
// voxels and drives each lit voxel onto the cube driver for DWELL cycles.
module led_cube_scanner #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       loop_en,
    input  logic       abort,
    output logic [8:0] rd_addr,
    input  logic [2:0] rd_data,
    output logic       drv_enable,
    output logic       drv_clear_n,
    output logic [3:0] oX,
    output logic [3:0] oY,
    output logic [3:0] oZ,
    output logic [3:0] color,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SHOW,
        NEXT,
        DONE
    } state_t;

    localparam logic [7:0] DWELL_LOAD = 8'(DWELL - 1);
    localparam logic [8:0] LAST_ADDR  = '1;

    state_t     state, state_n;
    logic [8:0] addr, addr_n;
    logic [2:0] col_r, col_n;
    logic [7:0] cnt, cnt_n;
    logic [8:0] hold_addr, hold_addr_n;
    logic [2:0] hold_col, hold_col_n;
    logic [8:0] shown_addr;
    logic [2:0] shown_col;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            addr      <= '0;
            col_r     <= '0;
            cnt       <= '0;
            hold_addr <= '0;
            hold_col  <= '0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            col_r     <= col_n;
            cnt       <= cnt_n;
            hold_addr <= hold_addr_n;
            hold_col  <= hold_col_n;
        end
    end

    always_comb begin
        state_n     = state;
        addr_n      = addr;
        col_n       = col_r;
        cnt_n       = cnt;
        hold_addr_n = hold_addr;
        hold_col_n  = hold_col;
        // Remember the voxel on the driver so it stays presented after SHOW ends.
        if (state == SHOW) begin
            hold_addr_n = addr;
            hold_col_n  = col_r;
        end
        if (abort) begin
            state_n = IDLE;
            addr_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_n = FETCH;
                        addr_n  = '0;
                    end
                end
                FETCH: state_n = WAIT;
                WAIT: begin
                    col_n = rd_data;
                    if (rd_data != '0) begin
                        state_n = SHOW;
                        cnt_n   = DWELL_LOAD;
                    end else begin
                        state_n = NEXT;
                    end
                end
                SHOW: begin
                    if (cnt == '0) state_n = NEXT;
                    else           cnt_n   = cnt - 8'd1;
                end
                NEXT: begin
                    if (addr == LAST_ADDR) begin
                        state_n = DONE;
                    end else begin
                        state_n = FETCH;
                        addr_n  = addr + 9'd1;
                    end
                end
                DONE: begin
                    if (loop_en) begin
                        state_n = FETCH;
                        addr_n  = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign shown_addr  = (state == SHOW) ? addr  : hold_addr;
    assign shown_col   = (state == SHOW) ? col_r : hold_col;

    assign rd_addr     = addr;
    assign drv_enable  = (state == SHOW);
    assign drv_clear_n = (state == FETCH) || (state == WAIT) || (state == SHOW);
    assign oX          = {1'b0, shown_addr[2:0]};
    assign oY          = {1'b0, shown_addr[5:3]};
    assign oZ          = {1'b0, shown_addr[8:6]};
    assign color       = {1'b0, shown_col};
    assign busy        = (state != IDLE);
    assign frame_done  = (state == DONE);

endmodule

// File: tb/tb_led_cube_scanner.sv
// Directed bench for led_cube_scanner: frame timing, lit-voxel drive window,
// loop mode, abort and asynchronous reset, with DWELL=4 and DWELL=1 instances.
module tb_led_cube_scanner;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start, loop_en, abort;
    logic [8:0] rd_addr;
    logic [2:0] rd_data;
    logic       drv_enable, drv_clear_n, busy, frame_done;
    logic [3:0] oX, oY, oZ, color;

    logic       start1;
    logic [8:0] rd_addr1;
    logic [2:0] rd_data1;
    logic       drv_enable1, drv_clear_n1, busy1, frame_done1;
    logic [3:0] oX1, oY1, oZ1, color1;

    logic [2:0] mem [512];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data  <= mem[rd_addr];
        rd_data1 <= mem[rd_addr1];
    end

    led_cube_scanner #(.DWELL(4)) dut (
        .clk(clk), .resetn(resetn), .start(start), .loop_en(loop_en), .abort(abort),
        .rd_addr(rd_addr), .rd_data(rd_data), .drv_enable(drv_enable),
        .drv_clear_n(drv_clear_n), .oX(oX), .oY(oY), .oZ(oZ), .color(color),
        .busy(busy), .frame_done(frame_done)
    );

    led_cube_scanner #(.DWELL(1)) dut1 (
        .clk(clk), .resetn(resetn), .start(start1), .loop_en(1'b0), .abort(1'b0),
        .rd_addr(rd_addr1), .rd_data(rd_data1), .drv_enable(drv_enable1),
        .drv_clear_n(drv_clear_n1), .oX(oX1), .oY(oY1), .oZ(oZ1), .color(color1),
        .busy(busy1), .frame_done(frame_done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic fill(input logic [2:0] v);
        for (int i = 0; i < 512; i++) mem[i] = v;
    endtask

    initial begin
        int nd, fd, en, first, last, bad, gap, t1, t2, t3;

        resetn = 1'b0; start = 1'b0; loop_en = 1'b0; abort = 1'b0; start1 = 1'b0;
        fill(3'd0);
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_drv_enable", 32'(drv_enable), 0);
        chk("rst_drv_clear_n", 32'(drv_clear_n), 0);
        chk("rst_coords", 32'({oX, oY, oZ, color}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_rst", 32'(busy), 0);

        // All-dark frame, with an ignored start pulse mid-frame
        run_start();
        chk("fetch_busy", 32'(busy), 1);
        chk("fetch_clear_n", 32'(drv_clear_n), 1);
        nd = 0; fd = 0; en = 0;
        for (int k = 1; k <= 1600; k++) begin
            if (k == 4)    chk("rd_addr_step", 32'(rd_addr), 1);
            if (k == 1537) chk("rd_addr_last", 32'(rd_addr), 511);
            if (k == 100) start = 1'b1;
            if (k == 101) start = 1'b0;
            if (drv_enable) en++;
            if (frame_done) begin
                nd++;
                if (fd == 0) fd = k;
            end
            @(negedge clk);
        end
        chk("dark_done_count", 32'(nd), 1);
        chk("dark_done_cycle", 32'(fd), 1537);
        chk("dark_no_enable", 32'(en), 0);
        chk("dark_idle_after", 32'(busy), 0);

        // Single lit voxel at 0x1A5, colour 5
        mem[9'h1A5] = 3'd5;
        run_start();
        fd = 0; en = 0; first = 0; last = 0; bad = 0;
        for (int k = 1; k <= 1600; k++) begin
            if (k == 1269) chk("show_clear_n_high", 32'(drv_clear_n), 1);
            if (k == 1270) chk("clear_after_show", 32'(drv_clear_n), 0);
            if (drv_enable) begin
                en++;
                if (first == 0) first = k;
                last = k;
                if (oX !== 4'd5 || oY !== 4'd4 || oZ !== 4'd6 || color !== 4'd5) bad++;
            end
            if (frame_done && fd == 0) fd = k;
            @(negedge clk);
        end
        chk("voxel_enable_cycles", 32'(en), 4);
        chk("voxel_first_enable", 32'(first), 1266);
        chk("voxel_last_enable", 32'(last), 1269);
        chk("voxel_coord_errors", 32'(bad), 0);
        chk("voxel_frame_len", 32'(fd), 1541);
        chk("held_oX", 32'(oX), 5);
        chk("held_color", 32'(color), 5);

        // Abort in the second SHOW cycle, together with start
        run_start();
        for (int k = 1; k < 1267; k++) @(negedge clk);
        chk("abort_pre_enable", 32'(drv_enable), 1);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_enable", 32'(drv_enable), 0);
        chk("abort_clear_n", 32'(drv_clear_n), 0);
        chk("abort_frame_done", 32'(frame_done), 0);
        chk("abort_addr", 32'(rd_addr), 0);
        nd = 0; gap = 0;
        for (int k = 0; k < 20; k++) begin
            if (frame_done) nd++;
            if (busy) gap++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(nd), 0);
        chk("abort_stays_idle", 32'(gap), 0);

        // Asynchronous reset mid-SHOW
        run_start();
        for (int k = 1; k < 1267; k++) @(negedge clk);
        chk("rst_pre_enable", 32'(drv_enable), 1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_enable", 32'(drv_enable), 0);
        chk("arst_clear_n", 32'(drv_clear_n), 0);
        chk("arst_coords", 32'({oX, oY, oZ, color}), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_rd_addr", 32'(rd_addr), 0);
        @(negedge clk);
        resetn = 1'b1;
        gap = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy || frame_done) gap++;
            @(negedge clk);
        end
        chk("arst_no_restart", 32'(gap), 0);
        run_start();
        chk("restart_addr", 32'(rd_addr), 0);
        chk("restart_busy", 32'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // Loop mode, loop_en dropped during the third frame
        fill(3'd0);
        loop_en = 1'b1;
        run_start();
        nd = 0; gap = 0; t1 = 0; t2 = 0; t3 = 0;
        for (int k = 1; k <= 4700; k++) begin
            if (k == 3500) loop_en = 1'b0;
            if (frame_done) begin
                nd++;
                if (nd == 1) t1 = k;
                if (nd == 2) t2 = k;
                if (nd == 3) t3 = k;
            end
            if (k <= 4611 && !busy) gap++;
            @(negedge clk);
        end
        chk("loop_done_count", 32'(nd), 3);
        chk("loop_done_1", 32'(t1), 1537);
        chk("loop_done_2", 32'(t2), 3074);
        chk("loop_done_3", 32'(t3), 4611);
        chk("loop_no_gap", 32'(gap), 0);
        chk("loop_idle_end", 32'(busy), 0);

        // All voxels colour 7 on the DWELL=1 instance
        fill(3'd7);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        en = 0; bad = 0; fd = 0;
        for (int k = 1; k <= 2100; k++) begin
            if (drv_enable1) begin
                en++;
                if ((k % 4) != 3 || color1 !== 4'd7) bad++;
            end
            if (k <= 2048 && (k % 4) == 3 && !drv_enable1) bad++;
            if (k <= 2048 && (k % 4) == 0 && drv_clear_n1 !== 1'b0) bad++;
            if (frame_done1 && fd == 0) fd = k;
            @(negedge clk);
        end
        chk("lit_enable_pulses", 32'(en), 512);
        chk("lit_pattern_errors", 32'(bad), 0);
        chk("lit_frame_len", 32'(fd), 2049);
        chk("lit_idle_end", 32'(busy1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
